// File: rtl/cgra_cfg_arb_pkg.sv
// Shared types and default widths for the CGRA configuration arbiter.
package cgra_cfg_arb_pkg;

  localparam int CGRA_CFG_ADDR_WIDTH_DEFAULT = 32;
  localparam int CGRA_CFG_DATA_WIDTH_DEFAULT = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cgra_cfg_arb_timer.sv
// Read-timeout counter: counts cycles while enabled, expired flags the last allowed cycle.
module cgra_cfg_arb_timer #(
  parameter int RD_TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of completed wait cycles, so the final one is RD_TIMEOUT-1
  assign expired = enable && (count == CW'(RD_TIMEOUT - 1));

endmodule

// File: rtl/cgra_cfg_arb.sv
// JTAG / parallel-config arbiter for the CGRA configuration port.
// Optional read timeout enabled by defining CGRA_CFG_ARB_RD_TIMEOUT_EN.
module cgra_cfg_arb
  import cgra_cfg_arb_pkg::*;
#(
  parameter int CGRA_CFG_ADDR_WIDTH = CGRA_CFG_ADDR_WIDTH_DEFAULT,
  parameter int CGRA_CFG_DATA_WIDTH = CGRA_CFG_DATA_WIDTH_DEFAULT,
  parameter int RD_TIMEOUT          = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           jtag_req_valid,
  input  logic                           jtag_req_wr,
  input  logic [CGRA_CFG_ADDR_WIDTH-1:0] jtag_req_addr,
  input  logic [CGRA_CFG_DATA_WIDTH-1:0] jtag_req_data,
  output logic                           jtag_req_ready,
  output logic                           jtag_rsp_valid,
  output logic [CGRA_CFG_DATA_WIDTH-1:0] jtag_rsp_data,
  output logic                           jtag_rsp_err,
  input  logic                           pc_req_valid,
  input  logic [CGRA_CFG_ADDR_WIDTH-1:0] pc_req_addr,
  input  logic [CGRA_CFG_DATA_WIDTH-1:0] pc_req_data,
  output logic                           pc_req_ready,
  output logic                           cfg_wr_en,
  output logic                           cfg_rd_en,
  output logic [CGRA_CFG_ADDR_WIDTH-1:0] cfg_addr,
  output logic [CGRA_CFG_DATA_WIDTH-1:0] cfg_data,
  input  logic [CGRA_CFG_DATA_WIDTH-1:0] cfg_rd_data,
  input  logic                           cfg_rd_data_valid,
  output logic                           busy
);

  arb_state_t state;
  logic       timer_expired;

  // JTAG has strict priority; nothing is accepted while a read is outstanding
  assign jtag_req_ready = (state == IDLE);
  assign pc_req_ready   = (state == IDLE) && !jtag_req_valid;
  assign busy           = (state != IDLE);

`ifdef CGRA_CFG_ARB_RD_TIMEOUT_EN
  logic rsp_err_q;

  cgra_cfg_arb_timer #(
    .RD_TIMEOUT(RD_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable (state == RD_WAIT),
    .expired(timer_expired)
  );

  assign jtag_rsp_err = rsp_err_q;
`else
  logic unused_rd_timeout;

  assign unused_rd_timeout = ^RD_TIMEOUT;
  assign timer_expired     = 1'b0;
  assign jtag_rsp_err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cfg_wr_en      <= 1'b0;
      cfg_rd_en      <= 1'b0;
      cfg_addr       <= '0;
      cfg_data       <= '0;
      jtag_rsp_valid <= 1'b0;
      jtag_rsp_data  <= '0;
`ifdef CGRA_CFG_ARB_RD_TIMEOUT_EN
      rsp_err_q      <= 1'b0;
`endif
    end else begin
      cfg_wr_en      <= 1'b0;
      cfg_rd_en      <= 1'b0;
      jtag_rsp_valid <= 1'b0;
`ifdef CGRA_CFG_ARB_RD_TIMEOUT_EN
      rsp_err_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (jtag_req_valid) begin
            cfg_addr <= jtag_req_addr;
            if (jtag_req_wr) begin
              cfg_wr_en <= 1'b1;
              cfg_data  <= jtag_req_data;
            end else begin
              cfg_rd_en <= 1'b1;
              state     <= RD_WAIT;
            end
          end else if (pc_req_valid) begin
            cfg_wr_en <= 1'b1;
            cfg_addr  <= pc_req_addr;
            cfg_data  <= pc_req_data;
          end
        end
        RD_WAIT: begin
          // returned data wins over a coincident timeout
          if (cfg_rd_data_valid) begin
            jtag_rsp_valid <= 1'b1;
            jtag_rsp_data  <= cfg_rd_data;
            state          <= IDLE;
          end else if (timer_expired) begin
            jtag_rsp_valid <= 1'b1;
            jtag_rsp_data  <= '0;
`ifdef CGRA_CFG_ARB_RD_TIMEOUT_EN
            rsp_err_q      <= 1'b1;
`endif
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_cfg_arb.sv
// Self-checking bench for cgra_cfg_arb: directed table, corner sequences, and random traffic vs a transaction model.
module tb_cgra_cfg_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;
`ifdef CGRA_CFG_ARB_RD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          jtag_req_valid, jtag_req_wr;
  logic [AW-1:0] jtag_req_addr;
  logic [DW-1:0] jtag_req_data;
  logic          jtag_req_ready;
  logic          jtag_rsp_valid;
  logic [DW-1:0] jtag_rsp_data;
  logic          jtag_rsp_err;
  logic          pc_req_valid;
  logic [AW-1:0] pc_req_addr;
  logic [DW-1:0] pc_req_data;
  logic          pc_req_ready;
  logic          cfg_wr_en, cfg_rd_en;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic [DW-1:0] cfg_rd_data;
  logic          cfg_rd_data_valid;
  logic          busy;

  cgra_cfg_arb #(
    .CGRA_CFG_ADDR_WIDTH(AW),
    .CGRA_CFG_DATA_WIDTH(DW),
    .RD_TIMEOUT         (TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .jtag_req_valid   (jtag_req_valid),
    .jtag_req_wr      (jtag_req_wr),
    .jtag_req_addr    (jtag_req_addr),
    .jtag_req_data    (jtag_req_data),
    .jtag_req_ready   (jtag_req_ready),
    .jtag_rsp_valid   (jtag_rsp_valid),
    .jtag_rsp_data    (jtag_rsp_data),
    .jtag_rsp_err     (jtag_rsp_err),
    .pc_req_valid     (pc_req_valid),
    .pc_req_addr      (pc_req_addr),
    .pc_req_data      (pc_req_data),
    .pc_req_ready     (pc_req_ready),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_rd_en        (cfg_rd_en),
    .cfg_addr         (cfg_addr),
    .cfg_data         (cfg_data),
    .cfg_rd_data      (cfg_rd_data),
    .cfg_rd_data_valid(cfg_rd_data_valid),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction-level model: is a read outstanding, and for how many cycles
  bit            m_wait;
  int            m_cnt;
  logic          e_wr, e_rd, e_rv, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data, e_rdata;

  typedef struct packed {
    logic          jv, jw;
    logic [AW-1:0] ja;
    logic [DW-1:0] jd;
    logic          pv;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic          rdv;
    logic [DW-1:0] rdd;
    logic          e_jr, e_pr, e_wr, e_rd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_busy, e_rv;
    logic [DW-1:0] e_rdata;
    logic          e_err;
  } vec_t;

  vec_t tbl[18];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic jv, input logic jw, input logic [AW-1:0] ja,
                               input logic [DW-1:0] jd, input logic pv, input logic [AW-1:0] pa,
                               input logic [DW-1:0] pd, input logic rdv, input logic [DW-1:0] rdd);
    jtag_req_valid    = jv;
    jtag_req_wr       = jw;
    jtag_req_addr     = ja;
    jtag_req_data     = jd;
    pc_req_valid      = pv;
    pc_req_addr       = pa;
    pc_req_data       = pd;
    cfg_rd_data_valid = rdv;
    cfg_rd_data       = rdd;
  endtask

  task automatic model_reset();
    m_wait  = 1'b0;
    m_cnt   = 0;
    e_wr    = 1'b0;
    e_rd    = 1'b0;
    e_rv    = 1'b0;
    e_err   = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    e_rdata = '0;
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle
  task automatic model_step();
    e_wr = 1'b0;
    e_rd = 1'b0;
    e_rv = 1'b0;
    e_err = 1'b0;
    if (!m_wait) begin
      if (jtag_req_valid) begin
        e_addr = jtag_req_addr;
        if (jtag_req_wr) begin
          e_wr   = 1'b1;
          e_data = jtag_req_data;
        end else begin
          e_rd   = 1'b1;
          m_wait = 1'b1;
          m_cnt  = 0;
        end
      end else if (pc_req_valid) begin
        e_wr   = 1'b1;
        e_addr = pc_req_addr;
        e_data = pc_req_data;
      end
    end else begin
      m_cnt++;
      if (cfg_rd_data_valid) begin
        e_rv    = 1'b1;
        e_rdata = cfg_rd_data;
        m_wait  = 1'b0;
      end else if (TO_EN && m_cnt == TO) begin
        e_rv    = 1'b1;
        e_err   = 1'b1;
        e_rdata = '0;
        m_wait  = 1'b0;
      end
    end
  endtask

  task automatic checkReadies();
    checkOutput("jtag_req_ready", 64'(jtag_req_ready), 64'(!m_wait));
    checkOutput("pc_req_ready", 64'(pc_req_ready), 64'(!m_wait && !jtag_req_valid));
  endtask

  task automatic checkModel();
    checkOutput("cfg_wr_en", 64'(cfg_wr_en), 64'(e_wr));
    checkOutput("cfg_rd_en", 64'(cfg_rd_en), 64'(e_rd));
    checkOutput("cfg_addr", 64'(cfg_addr), 64'(e_addr));
    checkOutput("cfg_data", 64'(cfg_data), 64'(e_data));
    checkOutput("busy", 64'(busy), 64'(m_wait));
    checkOutput("jtag_rsp_valid", 64'(jtag_rsp_valid), 64'(e_rv));
    if (e_rv) begin
      checkOutput("jtag_rsp_data", 64'(jtag_rsp_data), 64'(e_rdata));
      checkOutput("jtag_rsp_err", 64'(jtag_rsp_err), 64'(e_err));
    end
  endtask

  // Called #1 after a rising edge with inputs already applied
  task automatic run_cycle();
    #1;
    checkReadies();
    @(posedge clk);
    model_step();
    #1;
    checkModel();
  endtask

  task automatic idle_inputs();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    idle_inputs();
    model_reset();

    tbl[0]  = '{1, 1, 32'h0000_0203, 32'hA5A5_A5A5, 0, 0, 0, 0, 0,
                1, 0, 1, 0, 32'h0000_0203, 32'hA5A5_A5A5, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                1, 1, 0, 0, 32'h0000_0203, 32'hA5A5_A5A5, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 32'h10, 32'h11, 1, 32'h20, 32'h22, 0, 0,
                1, 0, 1, 0, 32'h10, 32'h11, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 32'h20, 32'h22, 0, 0,
                1, 1, 1, 0, 32'h20, 32'h22, 0, 0, 0, 0};
    for (int k = 0; k < 8; k++) begin
      tbl[4+k] = '{0, 0, 0, 0, 1, 32'h100 + k, 32'hC0DE_0000 + k, 0, 0,
                   1, 1, 1, 0, 32'h100 + k, 32'hC0DE_0000 + k, 0, 0, 0, 0};
    end
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                1, 1, 0, 0, 32'h107, 32'hC0DE_0007, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 32'h0000_1005, 0, 1, 32'h55, 32'h66, 0, 0,
                1, 0, 0, 1, 32'h0000_1005, 32'hC0DE_0007, 1, 0, 0, 0};
    tbl[14] = '{1, 1, 32'hBAD, 32'hBAD, 1, 32'hBAD, 32'hBAD, 0, 0,
                0, 0, 0, 0, 32'h0000_1005, 32'hC0DE_0007, 1, 0, 0, 0};
    tbl[15] = tbl[14];
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678,
                0, 0, 0, 0, 32'h0000_1005, 32'hC0DE_0007, 0, 1, 32'h1234_5678, 0};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD,
                1, 1, 0, 0, 32'h0000_1005, 32'hC0DE_0007, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    checkModel();
    checkReadies();
    reset = 1'b0;

    $display("[TB] directed table");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].jv, tbl[i].jw, tbl[i].ja, tbl[i].jd, tbl[i].pv, tbl[i].pa,
                    tbl[i].pd, tbl[i].rdv, tbl[i].rdd);
      #1;
      checkOutput($sformatf("tbl%0d.jtag_req_ready", i), 64'(jtag_req_ready), 64'(tbl[i].e_jr));
      checkOutput($sformatf("tbl%0d.pc_req_ready", i), 64'(pc_req_ready), 64'(tbl[i].e_pr));
      @(posedge clk);
      model_step();
      #1;
      checkOutput($sformatf("tbl%0d.cfg_wr_en", i), 64'(cfg_wr_en), 64'(tbl[i].e_wr));
      checkOutput($sformatf("tbl%0d.cfg_rd_en", i), 64'(cfg_rd_en), 64'(tbl[i].e_rd));
      checkOutput($sformatf("tbl%0d.cfg_addr", i), 64'(cfg_addr), 64'(tbl[i].e_addr));
      checkOutput($sformatf("tbl%0d.cfg_data", i), 64'(cfg_data), 64'(tbl[i].e_data));
      checkOutput($sformatf("tbl%0d.busy", i), 64'(busy), 64'(tbl[i].e_busy));
      checkOutput($sformatf("tbl%0d.jtag_rsp_valid", i), 64'(jtag_rsp_valid), 64'(tbl[i].e_rv));
      if (tbl[i].e_rv) begin
        checkOutput($sformatf("tbl%0d.jtag_rsp_data", i), 64'(jtag_rsp_data), 64'(tbl[i].e_rdata));
        checkOutput($sformatf("tbl%0d.jtag_rsp_err", i), 64'(jtag_rsp_err), 64'(tbl[i].e_err));
      end
    end

    $display("[TB] read with no returned data");
    applyStimulus(1'b1, 1'b0, 32'h2000, '0, 1'b0, '0, '0, 1'b0, '0);
    run_cycle();
    idle_inputs();
    seen = 0;
    for (int k = 0; k < TO + 6; k++) begin
      run_cycle();
      if (jtag_rsp_valid) seen++;
    end
    checkOutput("timeout_pulse_count", 64'(seen), TO_EN ? 64'd1 : 64'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 32'hFEED_0001);
    run_cycle();
    idle_inputs();
    run_cycle();

    $display("[TB] reset while a read is outstanding");
    applyStimulus(1'b1, 1'b0, 32'h3000, '0, 1'b0, '0, '0, 1'b0, '0);
    run_cycle();
    idle_inputs();
    run_cycle();
    run_cycle();
    reset = 1'b1;
    #1;
    model_reset();
    checkModel();
    checkReadies();
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 32'hBEEF_0002);
    run_cycle();
    idle_inputs();
    run_cycle();

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, $urandom, $urandom,
                    $urandom_range(0, 1) == 1, $urandom, $urandom,
                    $urandom_range(0, 3) == 0, $urandom);
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cgra_cfg_arb.md
CGRA_CFG_ARB -- requirements
Module: cgra_cfg_arb

Interface
REQ-001 Parameter CGRA_CFG_ADDR_WIDTH, default 32: configuration address width.
REQ-002 Parameter CGRA_CFG_DATA_WIDTH, default 32: configuration data width.
REQ-003 Parameter RD_TIMEOUT, default 64: cycles a read waits in RD_WAIT before it is aborted.
REQ-004 Clock and reset SHALL be: reset reset, asynchronous, active-high; clock clk.
REQ-005 jtag_req_valid, jtag_req_wr, jtag_req_addr, jtag_req_data SHALL be inputs of 1, 1, ADDR, DATA bits: JTAG request; jtag_req_wr=1 write, 0 read.
REQ-006 jtag_req_ready SHALL be a 1-bit output: JTAG request accepted this cycle.
REQ-007 jtag_rsp_valid, jtag_rsp_data, jtag_rsp_err SHALL be outputs of 1, DATA, 1 bits: read response pulse; err=timeout.
REQ-008 pc_req_valid, pc_req_addr, pc_req_data SHALL be inputs of 1, ADDR, DATA bits: parallel-config write stream.
REQ-009 pc_req_ready SHALL be a 1-bit output: parallel-config write accepted.
REQ-010 cfg_wr_en, cfg_rd_en, cfg_addr, cfg_data SHALL be outputs of 1, 1, ADDR, DATA bits: registered drive to the CGRA configuration interface.
REQ-011 cfg_rd_data, cfg_rd_data_valid SHALL be inputs of DATA, 1 bits: read return from the CGRA.
REQ-012 busy SHALL be a 1-bit output: high when state is not IDLE.

Function
REQ-013 The FSM SHALL have two states: IDLE and RD_WAIT.
REQ-014 A request is accepted on a clock edge where its valid and ready are both high; ready SHALL be combinational and SHALL NOT depend on ready.
REQ-015 In IDLE, jtag_req_ready=1 and pc_req_ready=!jtag_req_valid; JTAG has strict priority. In RD_WAIT both readies SHALL be 0.
REQ-016 An accepted write at edge N SHALL drive cfg_wr_en=1 with its addr/data for exactly the cycle after N; state stays IDLE, so back-to-back writes run at one per cycle.
REQ-017 An accepted JTAG read at edge N SHALL drive cfg_rd_en=1 with cfg_addr for exactly the cycle after N and SHALL enter RD_WAIT at edge N.
REQ-018 In RD_WAIT, the first cycle with cfg_rd_data_valid=1 SHALL capture cfg_rd_data; the next cycle SHALL carry jtag_rsp_valid=1, jtag_rsp_err=0 and the data; the state SHALL return to IDLE. This includes the cycle in which cfg_rd_en is high.
REQ-019 jtag_rsp_valid SHALL be a single-cycle pulse with no back-pressure. A new request MAY be accepted in the cycle the pulse is high.
REQ-020 cfg_rd_data_valid SHALL be ignored in IDLE.
REQ-021 When cfg_wr_en/cfg_rd_en are low, cfg_addr and cfg_data SHALL hold their last values.

Reset
REQ-022 Reset SHALL force state=IDLE, timer=0, and all outputs to 0: cfg_*, jtag_rsp_*, busy. Readies then follow REQ-015.
REQ-023 Reset during RD_WAIT SHALL drop the outstanding read with no response. A late cfg_rd_data_valid after reset SHALL be ignored.

Configuration
REQ-024 With CGRA_CFG_ARB_RD_TIMEOUT_EN defined:
- The timer SHALL count cycles in RD_WAIT.
- If RD_TIMEOUT cycles elapse with no valid, the FSM SHALL return to IDLE and pulse jtag_rsp_valid=1, jtag_rsp_err=1, jtag_rsp_data=0.
- If valid and expiry coincide, valid SHALL win.
REQ-025 Without CGRA_CFG_ARB_RD_TIMEOUT_EN:
- No timer SHALL be built.
- RD_WAIT SHALL wait indefinitely.
- jtag_rsp_err SHALL be tied to 0.

Structure
REQ-026 Package cgra_cfg_arb_pkg SHALL hold the state enum (IDLE, RD_WAIT) and the default address/data width constants.
REQ-027 The timeout counter SHALL be sub-module cgra_cfg_arb_timer, with inputs clear/enable and output expired. It SHALL only be instantiated under the macro.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Idle write: JTAG write addr=0x0000_0203, data=0xA5A5_A5A5 accepted at edge N -> cfg_wr_en=1 for one cycle after N with that addr/data; busy stays 0.
- Contention: jtag_req_valid and pc_req_valid both high -> pc_req_ready=0 and JTAG is granted. PC is granted the next cycle; both writes appear on consecutive cycles.
- Read: JTAG read addr=0x0000_1005, then cfg_rd_data=0x1234_5678 with valid 3 cycles later -> jtag_rsp_valid pulse, data=0x1234_5678, err=0. Both readies are 0 throughout RD_WAIT.
- Timeout (macro on, RD_TIMEOUT=64): read with no valid -> after 64 cycles rsp_valid=1, err=1, data=0. A valid arriving later is ignored.
- Reset in RD_WAIT: assert reset 2 cycles after cfg_rd_en -> all outputs 0 and state IDLE. A subsequent cfg_rd_data_valid produces no response.
- PC stream: 8 consecutive pc writes with JTAG idle -> cfg_wr_en high for 8 consecutive cycles with matching addr/data.
